encoder_sequencer: RTL and testbench
====================================

ENCODER_SEQUENCER -- requirements
Module: encoder_sequencer

Interface
REQ-001 Parameter ENC_LATENCY, default 6: cycles from enc_data change to valid enc_result, range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte buffer depth, power of 2, range 2..16.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_valid  in  1  one-cycle pulse from UART receiver: rx_data holds a new byte.
REQ-006 rx_data  in  8  received character.
REQ-007 interleaver_sel  in  2  interleaver choice from board switches; may change at any time.
REQ-008 enc_data  out  8  byte presented to the turbo encoder.
REQ-009 enc_select  out  2  interleaver select presented to the encoder.
REQ-010 enc_result  in  24  encoder output (systematic + 2 parity bytes).
REQ-011 tx_data  out  24  frame presented to the UART transmitter.
REQ-012 tx_start  out  1  one-cycle pulse: transmitter starts sending tx_data.
REQ-013 tx_busy  in  1  high while the transmitter is shifting a frame.
REQ-014 seq_busy  out  1  high when state is not IDLE or FIFO non-empty.
REQ-015 overrun  out  1  sticky: a received byte was dropped.
REQ-016 frame_count  out  8  frames handed to the transmitter, modulo 256.

Function
REQ-017 rx_valid SHALL push rx_data into the FIFO when not full, or when full with a pop in the same cycle.
REQ-018 rx_valid on a full FIFO with no same-cycle pop SHALL drop the byte and set overrun; FIFO contents unchanged.
REQ-019 FSM states SHALL be IDLE, LOAD, WAIT_ENC, SEND, WAIT_TX.
REQ-020 IDLE with FIFO non-empty SHALL pop the head byte into enc_data, latch interleaver_sel into enc_select, and go to LOAD.
REQ-021 LOAD SHALL last one cycle, load the wait counter with ENC_LATENCY-1, go to WAIT_ENC.
REQ-022 WAIT_ENC SHALL decrement the counter; at zero, capture enc_result into tx_data and go to SEND.
REQ-023 Total latency SHALL be pop edge to tx_data capture = ENC_LATENCY+1 cycles.
REQ-024 enc_data and enc_select SHALL stay constant from the pop until the next pop; interleaver_sel changes mid-frame SHALL not affect the current frame.
REQ-025 SEND SHALL assert tx_start for exactly one cycle on the first cycle tx_busy is low, then go to WAIT_TX; while tx_busy is high it SHALL hold.
REQ-026 WAIT_TX SHALL return to IDLE after tx_busy has been seen high and then low; frame_count SHALL increment on that transition, wrapping 255->0.
REQ-027 tx_data SHALL stay constant from capture until the next capture.
REQ-028 Bytes SHALL be encoded and transmitted in arrival order, one frame at a time, with no frame skipped or duplicated.

Reset
REQ-029 reset SHALL asynchronously force IDLE, an empty FIFO, and a zero wait counter.
REQ-030 Reset values SHALL be: enc_data 0, enc_select 0, tx_data 0, tx_start 0, seq_busy 0, overrun 0, frame_count 0.
REQ-031 reset mid-frame SHALL abandon the frame: no tx_start after release until a new byte arrives.

Configuration
REQ-032 Macro ENC_SEQ_STATUS_EN defined: overrun and frame_count SHALL behave as in REQ-018/REQ-026.
REQ-033 Macro ENC_SEQ_STATUS_EN undefined: overrun and frame_count SHALL be constant 0 and their registers SHALL be absent; all other behaviour unchanged.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the 24-bit frame width constant and the default ENC_LATENCY/FIFO_DEPTH values.
REQ-035 The byte buffer SHALL be one sub-module, seq_byte_fifo (synchronous FIFO with full/empty flags).

Verification
REQ-036 Single byte 0x41, interleaver_sel=2, tx_busy idle -> enc_data=0x41 and enc_select=2 after the pop; tx_data=enc_result ENC_LATENCY+1 cycles later; one tx_start pulse.
REQ-037 Bytes 0x10,0x20,0x30 back-to-back, transmitter busy 100 cycles per frame -> three tx_start pulses in order 0x10,0x20,0x30; frame_count=3.
REQ-038 FIFO_DEPTH+2 bytes while tx_busy is held high -> exactly one byte dropped, overrun=1, all others sent in order.
REQ-039 interleaver_sel toggles 0->3 during WAIT_ENC -> current frame keeps enc_select=0; next frame uses 3.
REQ-040 reset asserted in WAIT_ENC and in SEND -> all outputs reset immediately; no tx_start after release with the FIFO empty.
REQ-041 256 frames with ENC_SEQ_STATUS_EN defined -> frame_count wraps to 0; with the macro undefined -> overrun and frame_count stay 0 throughout.

Source files
------------

// File: rtl/encoder_sequencer_pkg.sv
// Shared state encoding, frame width and default parameters for encoder_sequencer.
package encoder_sequencer_pkg;

    localparam int FRAME_W         = 24;
    localparam int DEF_ENC_LATENCY = 6;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_ENC = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_TX  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/seq_byte_fifo.sv
// Synchronous byte FIFO with full/empty flags; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module seq_byte_fifo
    import encoder_sequencer_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/encoder_sequencer.sv
// Buffers UART bytes, feeds them one at a time to the turbo encoder and hands each
// encoded frame to the transmitter. Status outputs exist only with ENC_SEQ_STATUS_EN.
//   state      | meaning
//   S_IDLE     | waiting for a buffered byte; pops it into enc_data/enc_select
//   S_LOAD     | arms the encoder-latency down-counter
//   S_WAIT_ENC | counts down; captures enc_result into tx_data at zero
//   S_SEND     | waits for the transmitter to be free, pulses tx_start
//   S_WAIT_TX  | waits for tx_busy to rise and fall again
module encoder_sequencer
    import encoder_sequencer_pkg::*;
#(
    parameter int ENC_LATENCY = DEF_ENC_LATENCY,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic [1:0]         interleaver_sel,
    output logic [7:0]         enc_data,
    output logic [1:0]         enc_select,
    input  logic [FRAME_W-1:0] enc_result,
    output logic [FRAME_W-1:0] tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               seq_busy,
    output logic               overrun,
    output logic [7:0]         frame_count
);

    seq_state_t state;
    seq_state_t state_next;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       load_cnt;
    logic       capture;
    logic       tx_done;
    logic       seen_busy;
    logic [7:0] wait_cnt;

    seq_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_cnt   = 1'b0;
        capture    = 1'b0;
        tx_start   = 1'b0;
        tx_done    = 1'b0;
        case (state)
            S_IDLE: if (!fifo_empty) begin
                pop        = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                load_cnt   = 1'b1;
                state_next = S_WAIT_ENC;
            end
            S_WAIT_ENC: if (wait_cnt == 8'd0) begin
                capture    = 1'b1;
                state_next = S_SEND;
            end
            S_SEND: if (!tx_busy) begin
                tx_start   = 1'b1;
                state_next = S_WAIT_TX;
            end
            S_WAIT_TX: if (seen_busy && !tx_busy) begin
                tx_done    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_data   <= '0;
            enc_select <= '0;
            tx_data    <= '0;
            wait_cnt   <= '0;
            seen_busy  <= 1'b0;
        end else begin
            if (pop) begin
                enc_data   <= fifo_head;
                enc_select <= interleaver_sel;
            end
            if (load_cnt)
                wait_cnt <= 8'(ENC_LATENCY - 1);
            else if (state == S_WAIT_ENC && wait_cnt != 8'd0)
                wait_cnt <= wait_cnt - 8'd1;
            if (capture) tx_data <= enc_result;
            // The frame is finished only after the transmitter has gone busy and idle again.
            if (tx_done)
                seen_busy <= 1'b0;
            else if (state == S_WAIT_TX && tx_busy)
                seen_busy <= 1'b1;
        end
    end

    assign seq_busy = (state != S_IDLE) || !fifo_empty;

`ifdef ENC_SEQ_STATUS_EN
    logic       overrun_q;
    logic [7:0] frame_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (rx_valid && fifo_full && !pop) overrun_q <= 1'b1;
            if (tx_done) frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;
`else
    assign overrun     = 1'b0;
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_encoder_sequencer.sv
// Directed self-checking bench for encoder_sequencer with a delayed encoder model
// and a simple transmitter model.
module tb_encoder_sequencer;

    localparam int LAT   = 6;
    localparam int DEPTH = 4;
`ifdef ENC_SEQ_STATUS_EN
    localparam logic [7:0] STATUS_MASK = 8'hFF;
`else
    localparam logic [7:0] STATUS_MASK = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  interleaver_sel;
    logic [7:0]  enc_data;
    logic [1:0]  enc_select;
    logic [23:0] enc_result;
    logic [23:0] tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        seq_busy;
    logic        overrun;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder_sequencer #(.ENC_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .interleaver_sel (interleaver_sel),
        .enc_data        (enc_data),
        .enc_select      (enc_select),
        .enc_result      (enc_result),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .tx_busy         (tx_busy),
        .seq_busy        (seq_busy),
        .overrun         (overrun),
        .frame_count     (frame_count)
    );

    function automatic logic [23:0] enc_func(input logic [7:0] d, input logic [1:0] s);
        return {d, d ^ {4{s}}, {d[3:0], d[7:4]} ^ 8'hC3 ^ {6'd0, s}};
    endfunction

    // Encoder model: result reflects enc_data/enc_select LAT cycles later.
    logic [23:0] enc_pipe [LAT];
    always @(posedge clk) begin
        enc_pipe[0] <= enc_func(enc_data, enc_select);
        for (int i = 1; i < LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
    end
    assign enc_result = enc_pipe[LAT-1];

    // Transmitter model: busy for tx_len cycles after accepting tx_start.
    int   tx_len   = 5;
    int   busy_cnt = 0;
    logic tx_hold  = 1'b0;
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= tx_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || tx_hold;

    logic [23:0] sent_q [$];
    int   start_count = 0;
    int   dbl_start   = 0;
    logic start_prev  = 1'b0;
    always @(negedge clk) begin
        if (tx_start && start_prev) dbl_start++;
        if (tx_start && !start_prev) begin
            sent_q.push_back(tx_data);
            start_count++;
        end
        start_prev = tx_start;
    end

    task automatic do_reset();
        rx_valid = 1'b0;
        tx_hold  = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!seq_busy && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (enc_data !== 8'h00)     begin errors++; $display("FAIL reset_enc_data got %h want 00", enc_data); end
        checks++; if (enc_select !== 2'd0)    begin errors++; $display("FAIL reset_enc_select got %0d want 0", enc_select); end
        checks++; if (tx_data !== 24'h0)      begin errors++; $display("FAIL reset_tx_data got %h want 000000", tx_data); end
        checks++; if (tx_start !== 1'b0)      begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (seq_busy !== 1'b0)      begin errors++; $display("FAIL reset_seq_busy got %b want 0", seq_busy); end
        checks++; if (overrun !== 1'b0)       begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (frame_count !== 8'h00)  begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n0, q0;
        logic ok;
        do_reset();
        n0 = start_count; q0 = sent_q.size();
        tx_len = 5; interleaver_sel = 2'd2;
        rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", seq_busy); end
        @(negedge clk);
        checks++; if (enc_data !== 8'h41)  begin errors++; $display("FAIL single_enc_data got %h want 41", enc_data); end
        checks++; if (enc_select !== 2'd2) begin errors++; $display("FAIL single_enc_select got %0d want 2", enc_select); end
        interleaver_sel = 2'd1;
        repeat (LAT) @(negedge clk);
        checks++; if (tx_data !== 24'h0) begin errors++; $display("FAIL single_early_capture got %h want 000000", tx_data); end
        @(negedge clk);
        checks++; if (tx_data !== enc_func(8'h41, 2'd2)) begin errors++; $display("FAIL single_tx_data got %h want %h", tx_data, enc_func(8'h41, 2'd2)); end
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_tx_start got %b want 1", tx_start); end
        checks++; if (enc_select !== 2'd2) begin errors++; $display("FAIL single_sel_hold got %0d want 2", enc_select); end
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got busy want idle"); end
        checks++; if (start_count - n0 !== 1) begin errors++; $display("FAIL single_starts got %0d want 1", start_count - n0); end
        checks++; if (frame_count !== (8'd1 & STATUS_MASK)) begin errors++; $display("FAIL single_frame_count got %0d want %0d", frame_count, 8'd1 & STATUS_MASK); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int n0, q0;
        logic ok;
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30;
        do_reset();
        n0 = start_count; q0 = sent_q.size();
        tx_len = 100; interleaver_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = bytes[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        wait_idle(1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got busy want idle"); end
        checks++; if (start_count - n0 !== 3) begin errors++; $display("FAIL b2b_starts got %0d want 3", start_count - n0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sent_q.size() <= q0 + i) begin
                errors++; $display("FAIL b2b_frame%0d got none want %h", i, enc_func(bytes[i], 2'd1));
            end else if (sent_q[q0+i] !== enc_func(bytes[i], 2'd1)) begin
                errors++; $display("FAIL b2b_frame%0d got %h want %h", i, sent_q[q0+i], enc_func(bytes[i], 2'd1));
            end
        end
        checks++; if (frame_count !== (8'd3 & STATUS_MASK)) begin errors++; $display("FAIL b2b_frame_count got %0d want %0d", frame_count, 8'd3 & STATUS_MASK); end
    endtask

    task automatic test_overrun();
        int n0, q0;
        logic ok;
        do_reset();
        n0 = start_count; q0 = sent_q.size();
        tx_len = 10; interleaver_sel = 2'd0; tx_hold = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rx_valid = 1'b1; rx_data = 8'h80 + 8'(i);
            if (i == DEPTH + 1) begin
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        checks++; if (overrun !== (1'b1 & STATUS_MASK[0])) begin errors++; $display("FAIL ovr_flag got %b want %b", overrun, STATUS_MASK[0]); end
        tx_hold = 1'b0;
        wait_idle(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_timeout got busy want idle"); end
        checks++; if (start_count - n0 !== DEPTH + 1) begin errors++; $display("FAIL ovr_starts got %0d want %0d", start_count - n0, DEPTH + 1); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            checks++;
            if (sent_q.size() <= q0 + i) begin
                errors++; $display("FAIL ovr_frame%0d got none want %h", i, enc_func(8'h80 + 8'(i), 2'd0));
            end else if (sent_q[q0+i] !== enc_func(8'h80 + 8'(i), 2'd0)) begin
                errors++; $display("FAIL ovr_frame%0d got %h want %h", i, sent_q[q0+i], enc_func(8'h80 + 8'(i), 2'd0));
            end
        end
        checks++; if (overrun !== STATUS_MASK[0]) begin errors++; $display("FAIL ovr_sticky got %b want %b", overrun, STATUS_MASK[0]); end
    endtask

    task automatic test_sel_change();
        int q0;
        logic ok;
        do_reset();
        q0 = sent_q.size();
        tx_len = 4; interleaver_sel = 2'd0;
        rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk);
        rx_data = 8'h5A;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        interleaver_sel = 2'd3;
        repeat (3) @(negedge clk);
        checks++; if (enc_select !== 2'd0) begin errors++; $display("FAIL sel_hold got %0d want 0", enc_select); end
        wait_idle(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sel_timeout got busy want idle"); end
        checks++;
        if (sent_q.size() < q0 + 2) begin
            errors++; $display("FAIL sel_frames got %0d want 2", sent_q.size() - q0);
        end else begin
            if (sent_q[q0] !== enc_func(8'hA5, 2'd0)) begin errors++; $display("FAIL sel_frame0 got %h want %h", sent_q[q0], enc_func(8'hA5, 2'd0)); end
            checks++;
            if (sent_q[q0+1] !== enc_func(8'h5A, 2'd3)) begin errors++; $display("FAIL sel_frame1 got %h want %h", sent_q[q0+1], enc_func(8'h5A, 2'd3)); end
        end
        checks++; if (enc_select !== 2'd3) begin errors++; $display("FAIL sel_next got %0d want 3", enc_select); end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        tx_len = 5; interleaver_sel = 2'd1;
        rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (enc_data !== 8'h00) begin errors++; $display("FAIL rst_wait_enc_data got %h want 00", enc_data); end
        checks++; if (enc_select !== 2'd0) begin errors++; $display("FAIL rst_wait_enc_select got %0d want 0", enc_select); end
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy got %b want 0", seq_busy); end
        n0 = start_count;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (start_count !== n0) begin errors++; $display("FAIL rst_wait_no_start got %0d want %0d", start_count, n0); end
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_wait_idle got %b want 0", seq_busy); end

        tx_hold = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h66;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        checks++; if (tx_data !== enc_func(8'h66, 2'd1)) begin errors++; $display("FAIL rst_send_pre got %h want %h", tx_data, enc_func(8'h66, 2'd1)); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx_data !== 24'h0) begin errors++; $display("FAIL rst_send_tx_data got %h want 000000", tx_data); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_send_tx_start got %b want 0", tx_start); end
        checks++; if (enc_data !== 8'h00) begin errors++; $display("FAIL rst_send_enc_data got %h want 00", enc_data); end
        tx_hold = 1'b0;
        n0 = start_count;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (start_count !== n0) begin errors++; $display("FAIL rst_send_no_start got %0d want %0d", start_count, n0); end
        checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL rst_send_idle got %b want 0", seq_busy); end
    endtask

    task automatic test_wrap();
        int q0;
        logic ok;
        logic [7:0] b;
        do_reset();
        q0 = sent_q.size();
        tx_len = 2;
        for (int f = 0; f < 256; f++) begin
            b = 8'(f) ^ 8'h3C;
            interleaver_sel = 2'(f);
            rx_valid = 1'b1; rx_data = b;
            @(negedge clk);
            rx_valid = 1'b0;
            wait_idle(100, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++; $display("FAIL wrap_timeout frame %0d got busy want idle", f);
            end else if (sent_q.size() != q0 + f + 1) begin
                errors++; $display("FAIL wrap_count frame %0d got %0d want %0d", f, sent_q.size() - q0, f + 1);
            end else if (sent_q[q0+f] !== enc_func(b, 2'(f))) begin
                errors++; $display("FAIL wrap_data frame %0d got %h want %h", f, sent_q[q0+f], enc_func(b, 2'(f)));
            end
            checks++;
            if (frame_count !== (8'(f + 1) & STATUS_MASK)) begin
                errors++; $display("FAIL wrap_frame_count frame %0d got %0d want %0d", f, frame_count, 8'(f + 1) & STATUS_MASK);
            end
        end
        checks++; if (frame_count !== 8'h00) begin errors++; $display("FAIL wrap_final got %0d want 0", frame_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL wrap_overrun got %b want 0", overrun); end
        checks++; if (dbl_start !== 0) begin errors++; $display("FAIL tx_start_width got %0d long pulses want 0", dbl_start); end
    endtask

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        interleaver_sel = 2'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_sel_change();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit");
    end

endmodule
